// File: rtl/shooter_runup.sv
// Shooter sprite run-up FSM: idle at the spot, run to the ball, hold contact, walk back.
// One position/animation update per frame_clk; player_at_ball is the handshake to the ball FSM.
module shooter_runup #(
    parameter int unsigned START_X     = 320,
    parameter int unsigned START_Y     = 420,
    parameter int unsigned BALL_X      = 320,
    parameter int unsigned KICK_Y      = 381,
    parameter int unsigned SIDE_OFS    = 8,
    parameter int unsigned RUN_STEP    = 2,
    parameter int unsigned KICK_FRAMES = 8,
    parameter int unsigned ANIM_DIV    = 4
) (
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode_shooter,
    output logic [9:0] ShooterX,
    output logic [9:0] ShooterY,
    output logic [9:0] ShooterS,
    output logic       player_at_ball,
    output logic [1:0] shooter_dir,
    output logic [1:0] anim_frame,
    output logic       busy
);

    localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int KCW = (KICK_FRAMES > 1) ? $clog2(KICK_FRAMES) : 1;

    localparam logic [9:0] SX      = 10'(START_X);
    localparam logic [9:0] SY      = 10'(START_Y);
    localparam logic [9:0] KY      = 10'(KICK_Y);
    localparam logic [9:0] STEP    = 10'(RUN_STEP);
    localparam logic [9:0] TGT_UP  = 10'(BALL_X);
    localparam logic [9:0] TGT_LFT = 10'(BALL_X + SIDE_OFS);
    localparam logic [9:0] TGT_RGT = 10'(BALL_X - SIDE_OFS);
    // Saturation thresholds, compared before the step so Y never wraps
    localparam logic [9:0] RUN_SAT = 10'(KICK_Y + RUN_STEP);
    localparam logic [9:0] RET_SAT = 10'(START_Y - RUN_STEP);
    localparam logic [ACW-1:0] ANIM_LAST = ACW'(ANIM_DIV - 1);
    localparam logic [KCW-1:0] KICK_LOAD = KCW'(KICK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, RUN_UP, KICK, RETURN} state_t;

    state_t         state, state_nxt;
    logic [9:0]     x_q, x_nxt, y_q, y_nxt, tgt_x;
    logic           pab_q, pab_nxt;
    logic [1:0]     dir_q, dir_nxt, frame_q, frame_nxt;
    logic [ACW-1:0] anim_cnt, anim_nxt;
    logic [KCW-1:0] kick_cnt, kick_nxt;

    function automatic logic [9:0] toward(input logic [9:0] cur, input logic [9:0] tgt);
        if (cur < tgt)      return cur + 10'd1;
        else if (cur > tgt) return cur - 10'd1;
        else                return cur;
    endfunction

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            x_q      <= SX;
            y_q      <= SY;
            pab_q    <= 1'b0;
            dir_q    <= 2'd0;
            frame_q  <= 2'd0;
            anim_cnt <= '0;
            kick_cnt <= '0;
        end else begin
            state    <= state_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            pab_q    <= pab_nxt;
            dir_q    <= dir_nxt;
            frame_q  <= frame_nxt;
            anim_cnt <= anim_nxt;
            kick_cnt <= kick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        y_nxt     = y_q;
        pab_nxt   = pab_q;
        dir_nxt   = dir_q;
        frame_nxt = frame_q;
        anim_nxt  = anim_cnt;
        kick_nxt  = kick_cnt;

        case (dir_q)
            2'd1:    tgt_x = TGT_LFT;
            2'd2:    tgt_x = TGT_RGT;
            default: tgt_x = TGT_UP;
        endcase

        // Walking states step the animation; entry into KICK/IDLE overrides below
        if (state == RUN_UP || state == RETURN) begin
            if (anim_cnt == ANIM_LAST) begin
                anim_nxt  = '0;
                frame_nxt = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
            end else begin
                anim_nxt = anim_cnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                frame_nxt = 2'd0;
                case (keycode_shooter)
                    8'h1A: begin dir_nxt = 2'd0; state_nxt = RUN_UP; anim_nxt = '0; end
                    8'h04: begin dir_nxt = 2'd1; state_nxt = RUN_UP; anim_nxt = '0; end
                    8'h07: begin dir_nxt = 2'd2; state_nxt = RUN_UP; anim_nxt = '0; end
                    default: ;
                endcase
            end
            RUN_UP: begin
                x_nxt = toward(x_q, tgt_x);
                y_nxt = (y_q < RUN_SAT) ? KY : y_q - STEP;
                if (x_nxt == tgt_x && y_nxt == KY) begin
                    state_nxt = KICK;
                    pab_nxt   = 1'b1;
                    kick_nxt  = KICK_LOAD;
                    frame_nxt = 2'd3;
                end
            end
            KICK: begin
                if (kick_cnt == '0) begin
                    pab_nxt   = 1'b0;
                    state_nxt = RETURN;
                    anim_nxt  = '0;
                    frame_nxt = 2'd0;
                end else begin
                    kick_nxt = kick_cnt - 1'b1;
                end
            end
            RETURN: begin
                x_nxt = toward(x_q, SX);
                y_nxt = (y_q > RET_SAT) ? SY : y_q + STEP;
                if (x_nxt == SX && y_nxt == SY) begin
                    state_nxt = IDLE;
                    anim_nxt  = '0;
                    frame_nxt = 2'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ShooterX       = x_q;
    assign ShooterY       = y_q;
    assign ShooterS       = 10'd24;
    assign player_at_ball = pab_q;
    assign shooter_dir    = dir_q;
    assign anim_frame     = frame_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_shooter_runup.sv
// Scoreboard bench for shooter_runup: expected per-frame outputs derived from run-up timing formulas.
module tb_shooter_runup;

    logic       Reset, frame_clk;
    logic [7:0] keycode_shooter;
    logic [9:0] ShooterX, ShooterY, ShooterS;
    logic       player_at_ball, busy;
    logic [1:0] shooter_dir, anim_frame;

    shooter_runup dut (
        .Reset(Reset), .frame_clk(frame_clk), .keycode_shooter(keycode_shooter),
        .ShooterX(ShooterX), .ShooterY(ShooterY), .ShooterS(ShooterS),
        .player_at_ball(player_at_ball), .shooter_dir(shooter_dir),
        .anim_frame(anim_frame), .busy(busy)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pab;
        logic [1:0] dir;
        logic [1:0] frame;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t idle_exp(input int dir);
        exp_t e;
        e.x = 10'd320; e.y = 10'd420; e.pab = 1'b0;
        e.dir = 2'(dir); e.frame = 2'd0; e.busy = 1'b0;
        return e;
    endfunction

    // Expected outputs after the n-th edge of a run (edge 1 = key seen in IDLE)
    function automatic exp_t run_exp(input int dir, input int n);
        exp_t e;
        int s, tx, j, m;
        s  = (dir == 1) ? 1 : (dir == 2) ? -1 : 0;
        tx = 320 + 8 * s;
        e.dir = 2'(dir); e.busy = 1'b1; e.pab = 1'b0;
        if (n <= 20) begin
            j = n - 1;
            e.x = 10'(320 + s * ((j < 8) ? j : 8));
            e.y = 10'(420 - 2 * j);
            e.frame = 2'((j / 4) % 3);
        end else if (n <= 28) begin
            e.x = 10'(tx); e.y = 10'd381; e.pab = 1'b1; e.frame = 2'd3;
        end else if (n <= 48) begin
            m = n - 29;
            e.x = 10'(tx - s * ((m < 8) ? m : 8));
            e.y = 10'(381 + 2 * m);
            e.frame = 2'((m / 4) % 3);
        end else begin
            e = idle_exp(dir);
        end
        return e;
    endfunction

    task automatic step(input logic [7:0] key);
        exp_t e;
        @(negedge frame_clk);
        keycode_shooter = key;
        @(posedge frame_clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("X", int'(ShooterX), int'(e.x));
            chk("Y", int'(ShooterY), int'(e.y));
            chk("pab", int'(player_at_ball), int'(e.pab));
            chk("dir", int'(shooter_dir), int'(e.dir));
            chk("frame", int'(anim_frame), int'(e.frame));
            chk("busy", int'(busy), int'(e.busy));
        end
    endtask

    // noise is driven on edges 5..6 to show keys are ignored mid-run
    task automatic run(input logic [7:0] key, input int dir, input int nedges,
                       input bit hold, input logic [7:0] noise);
        for (int n = 1; n <= nedges; n++) begin
            sb.push_back(run_exp(dir, n));
            if (n == 1 || hold)       step(key);
            else if (n == 5 || n == 6) step(noise);
            else                       step(8'h00);
        end
    endtask

    task automatic idle_steps(input logic [7:0] key, input int dir, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            sb.push_back(idle_exp(dir));
            step(key);
        end
    endtask

    initial begin
        Reset = 1'b1;
        keycode_shooter = 8'h00;
        #12;
        chk("rst_X", int'(ShooterX), 320);
        chk("rst_Y", int'(ShooterY), 420);
        chk("rst_pab", int'(player_at_ball), 0);
        chk("rst_dir", int'(shooter_dir), 0);
        chk("rst_frame", int'(anim_frame), 0);
        chk("rst_busy", int'(busy), 0);
        chk("size", int'(ShooterS), 24);
        @(negedge frame_clk);
        Reset = 1'b0;

        idle_steps(8'h05, 0, 3);
        run(8'h1A, 0, 49, 1'b0, 8'h00);
        run(8'h04, 1, 49, 1'b0, 8'h07);
        idle_steps(8'h05, 1, 3);
        run(8'h07, 2, 49, 1'b0, 8'h1A);

        // Asynchronous reset between edges while in contact with the ball
        run(8'h1A, 0, 24, 1'b0, 8'h00);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_pab", int'(player_at_ball), 0);
        chk("arst_X", int'(ShooterX), 320);
        chk("arst_Y", int'(ShooterY), 420);
        chk("arst_busy", int'(busy), 0);
        chk("arst_frame", int'(anim_frame), 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        run(8'h1A, 0, 49, 1'b0, 8'h00);

        // Held key: the run-up re-arms on the edge after returning to IDLE
        run(8'h1A, 0, 49, 1'b1, 8'h00);
        run(8'h1A, 0, 49, 1'b1, 8'h00);
        idle_steps(8'h00, 0, 2);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/shooter_runup.md
Name: shooter_runup

Overview:
- Drives the shooter sprite through a penalty run-up: idle at the spot, run to the ball, kick contact, walk back.
- Produces the player_at_ball handshake that the ball FSM waits on in its WAIT_PLAYER state.
- Watches the same shooter keycode (W/A/D) as the ball FSM, so both leave idle on the same frame.
- Feeds sprite position, direction and animation frame to the renderer; one update per frame_clk.

Parameters:
- START_X, 320, shooter idle X (px)
- START_Y, 420, shooter idle Y (px)
- BALL_X, 320, ball rest X (px)
- KICK_Y, 381, shooter Y at ball contact (px)
- SIDE_OFS, 8, lateral offset from BALL_X for angled shots (px)
- RUN_STEP, 2, Y pixels per frame while running/returning
- KICK_FRAMES, 8, frames player_at_ball stays high
- ANIM_DIV, 4, frames per run-animation step

Ports:
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  frame clock (one edge per video frame)
- keycode_shooter  in  8  shooter keycode (0x1A=W, 0x04=A, 0x07=D)
- ShooterX  out  10  sprite X
- ShooterY  out  10  sprite Y
- ShooterS  out  10  sprite size, constant 24
- player_at_ball  out  1  high while shooter is in contact with the ball
- shooter_dir  out  2  latched shot: 0=up, 1=left, 2=right
- anim_frame  out  2  sprite frame index
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE, ShooterX=START_X, ShooterY=START_Y, player_at_ball=0, shooter_dir=0, anim_frame=0, anim counter=0, kick counter=0. All outputs are registered except ShooterS and busy (busy = state!=IDLE).
- States: IDLE, RUN_UP, KICK, RETURN.
- IDLE:
  - keycode 0x1A/0x04/0x07 latches shooter_dir 0/1/2 and goes to RUN_UP. Position does not change on this edge.
  - Any other keycode is ignored.
- Target X: dir 0 is BALL_X; dir 1 is BALL_X+SIDE_OFS (stand right, kick left); dir 2 is BALL_X-SIDE_OFS.
- RUN_UP, each edge:
  - X moves 1 px toward target X (no move when equal).
  - Y decreases by RUN_STEP, saturating at KICK_Y (if Y-RUN_STEP < KICK_Y then Y=KICK_Y).
  - If the next X equals the target and the next Y equals KICK_Y: on the same edge go to KICK, set player_at_ball=1 and load the kick counter with KICK_FRAMES-1.
- KICK:
  - Position frozen; the kick counter decrements each edge.
  - On the edge where the counter is 0: clear player_at_ball and go to RETURN.
  - player_at_ball is high for exactly KICK_FRAMES edges.
- RETURN, each edge:
  - X moves 1 px toward START_X; Y increases by RUN_STEP, saturating at START_Y.
  - When the next position equals (START_X, START_Y): go to IDLE.
- Keycodes are ignored outside IDLE. A key still held on re-entry to IDLE starts a new run-up on the next edge, consistent with the ball FSM re-arming.
- anim_frame:
  - IDLE is 0; KICK is 3.
  - RUN_UP/RETURN cycle 0→1→2→0, advancing every ANIM_DIV edges.
  - The anim counter clears on entry to RUN_UP and to RETURN.
- Arithmetic: 10-bit unsigned. Saturation compares are done before the subtract/add so there is no wrap below 0 or above 1023.
- Reset mid-KICK drops player_at_ball immediately (async).

Test Plan:
- W run-up: key 0x1A held 1 frame from IDLE → RUN_UP at edge 1, X stays 320, Y 418,416,…,382 then 381 at edge 21; KICK and player_at_ball=1 from edge 21 through edge 28; RETURN at edge 29; dir=0.
- A run-up: key 0x04 → X reaches 328 after 8 RUN_UP edges, Y reaches 381 after 20; KICK entered at edge 21; shooter_dir=1; RETURN reaches (320,420) after 20 edges (last step clamps 419→420), then IDLE, busy=0.
- Ignored keys: 0x05 in IDLE → stays IDLE, outputs unchanged. 0x07 pressed during RUN_UP → shooter_dir unchanged, trajectory unchanged.
- Animation: during RUN_UP, anim_frame holds 0 for 4 edges, then 1, then 2, then 0; it is 3 throughout KICK and 0 in IDLE.
- Async reset asserted mid-KICK (between clock edges) → player_at_ball=0, X=320, Y=420, state IDLE immediately; after release, a new W press repeats the 21-edge timing.
- Held key: 0x1A held continuously → after RETURN reaches IDLE, the next edge re-enters RUN_UP; player_at_ball pulses again for 8 frames.
